// File: rtl/vm2002_pkg.sv
// Shared types and constants for the vm2002 vending datapath.
package vm2002_pkg;

  // Coin encoding shared by the payout port and the refill port.
  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_t;

  localparam int unsigned CENTS_NICKEL  = 5;
  localparam int unsigned CENTS_DIME    = 10;
  localparam int unsigned CENTS_QUARTER = 25;

  // Change dispenser control states.
  typedef enum logic [2:0] {
    CD_IDLE   = 3'd0,
    CD_SELECT = 3'd1,
    CD_EMIT   = 3'd2,
    CD_DONE   = 3'd3,
    CD_ERR    = 3'd4
  } cd_state_t;

  // Face value in cents of a coin code.
  function automatic int unsigned coin_cents(input coin_t c);
    case (c)
      COIN_NICKEL:  return CENTS_NICKEL;
      COIN_DIME:    return CENTS_DIME;
      COIN_QUARTER: return CENTS_QUARTER;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/vm2002_coin_inventory.sv
// Three saturating coin counters (index 0 nickel, 1 dime, 2 quarter) with refill and payout decrement.
module vm2002_coin_inventory
  import vm2002_pkg::*;
#(
  parameter int unsigned INV_W  = 8,
  parameter int unsigned INIT_Q = 20,
  parameter int unsigned INIT_D = 20,
  parameter int unsigned INIT_N = 20
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             refill_valid,
  input  logic [1:0]       refill_coin,
  input  logic [INV_W-1:0] refill_count,
  input  logic [2:0]       dec,
  output logic [INV_W-1:0] q_cnt,
  output logic [INV_W-1:0] d_cnt,
  output logic [INV_W-1:0] n_cnt,
  output logic [2:0]       nz_c
);

  logic [INV_W-1:0] cnt_q [3];
  logic [INV_W-1:0] cnt_d [3];

  // Add then decrement in one extra bit so a same-cycle refill and payout nets to +count-1 before clamping.
  function automatic logic [INV_W-1:0] sat_step(input logic [INV_W-1:0] cnt,
                                                input logic [INV_W-1:0] add,
                                                input logic             take);
    logic [INV_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, add};
    if (take && (sum != '0)) sum = sum - (INV_W+1)'(1);
    if (sum > {1'b0, {INV_W{1'b1}}}) return '1;
    return sum[INV_W-1:0];
  endfunction

  // Next inventory per coin and nonzero flags for the greedy selector.
  always_comb begin
    nz_c = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = sat_step(cnt_q[i],
                          (refill_valid && (refill_coin == 2'(i + 1))) ? refill_count : INV_W'(0),
                          dec[i]);
      nz_c[i]  = (cnt_q[i] != '0);
    end
  end

  // Inventory registers; only a hard reset restores the initial stock.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      cnt_q[0] <= INV_W'(INIT_N);
      cnt_q[1] <= INV_W'(INIT_D);
      cnt_q[2] <= INV_W'(INIT_Q);
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign n_cnt = cnt_q[0];
  assign d_cnt = cnt_q[1];
  assign q_cnt = cnt_q[2];

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Pays a change balance out one coin at a time, greedy largest-first, with inventory and ack timeout.
module vm2002_change_dispenser
  import vm2002_pkg::*;
#(
  parameter int unsigned BAL_W  = 16,
  parameter int unsigned INV_W  = 8,
  parameter int unsigned INIT_Q = 20,
  parameter int unsigned INIT_D = 20,
  parameter int unsigned INIT_N = 20,
  parameter int unsigned ACK_TO = 512
) (
  input  logic             clk,
  input  logic             hrst_n,
  input  logic             srst,
  input  logic [BAL_W-1:0] balance_in,
  input  logic             balance_valid,
  output logic             ready,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             refill_valid,
  input  logic [1:0]       refill_coin,
  input  logic [INV_W-1:0] refill_count,
  output logic             done,
  output logic             error,
  output logic [BAL_W-1:0] residual,
  output logic [INV_W-1:0] q_cnt,
  output logic [INV_W-1:0] d_cnt,
  output logic [INV_W-1:0] n_cnt
);

  localparam int unsigned TMR_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  cd_state_t        state_q,      state_d;
  logic [BAL_W-1:0] remaining_q,  remaining_d;
  logic [BAL_W-1:0] residual_q,   residual_d;
  logic [TMR_W-1:0] timer_q,      timer_d;
  coin_t            coin_out_q,   coin_out_d;
  logic             coin_valid_q, coin_valid_d;
  logic             done_q,       done_d;
  logic             error_q,      error_d;
  logic             ready_q,      ready_d;
  coin_t            pick;
  logic [2:0]       dec_c;
  logic [2:0]       nz_c;

  vm2002_coin_inventory #(
    .INV_W  (INV_W),
    .INIT_Q (INIT_Q),
    .INIT_D (INIT_D),
    .INIT_N (INIT_N)
  ) u_inv (
    .clk          (clk),
    .hrst_n       (hrst_n),
    .refill_valid (refill_valid),
    .refill_coin  (refill_coin),
    .refill_count (refill_count),
    .dec          (dec_c),
    .q_cnt        (q_cnt),
    .d_cnt        (d_cnt),
    .n_cnt        (n_cnt),
    .nz_c         (nz_c)
  );

  // Next state, payout bookkeeping and registered output values.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    residual_d   = residual_q;
    timer_d      = timer_q;
    coin_out_d   = coin_out_q;
    coin_valid_d = coin_valid_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    pick         = COIN_NONE;
    dec_c        = '0;

    case (state_q)
      CD_IDLE: begin
        if (balance_valid) begin
          remaining_d = balance_in;
          if (balance_in == '0) begin
            state_d = CD_DONE;
          end else if ((balance_in % BAL_W'(CENTS_NICKEL)) != '0) begin
            residual_d = balance_in;
            state_d    = CD_ERR;
          end else begin
            state_d = CD_SELECT;
          end
        end
      end

      CD_SELECT: begin
        if (remaining_q >= BAL_W'(CENTS_QUARTER) && nz_c[2])   pick = COIN_QUARTER;
        else if (remaining_q >= BAL_W'(CENTS_DIME) && nz_c[1]) pick = COIN_DIME;
        else if (remaining_q >= BAL_W'(CENTS_NICKEL) && nz_c[0]) pick = COIN_NICKEL;

        if (remaining_q == '0) begin
          state_d = CD_DONE;
        end else if (pick != COIN_NONE) begin
          coin_out_d   = pick;
          coin_valid_d = 1'b1;
          timer_d      = TMR_W'(ACK_TO - 1);
          state_d      = CD_EMIT;
        end else begin
          residual_d = remaining_q;
          state_d    = CD_ERR;
        end
      end

      CD_EMIT: begin
        if (coin_ack) begin
          remaining_d  = remaining_q - BAL_W'(coin_cents(coin_out_q));
          dec_c        = {coin_out_q == COIN_QUARTER, coin_out_q == COIN_DIME,
                          coin_out_q == COIN_NICKEL};
          coin_out_d   = COIN_NONE;
          coin_valid_d = 1'b0;
          state_d      = CD_SELECT;
        end else if (timer_q == '0) begin
          // Unacked coin is treated as never released, so it stays in remaining.
          residual_d   = remaining_q;
          coin_out_d   = COIN_NONE;
          coin_valid_d = 1'b0;
          state_d      = CD_ERR;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      CD_DONE: begin
        done_d     = 1'b1;
        residual_d = '0;
        state_d    = CD_IDLE;
      end

      CD_ERR: begin
        error_d = 1'b1;
        state_d = CD_IDLE;
      end

      default: state_d = CD_IDLE;
    endcase

    // Soft reset abandons any coin in flight; its ack must not touch inventory.
    if (srst) begin
      state_d      = CD_IDLE;
      remaining_d  = '0;
      residual_d   = '0;
      timer_d      = TMR_W'(ACK_TO - 1);
      coin_out_d   = COIN_NONE;
      coin_valid_d = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      dec_c        = '0;
    end

    ready_d = (state_d == CD_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q      <= CD_IDLE;
      remaining_q  <= '0;
      residual_q   <= '0;
      timer_q      <= TMR_W'(ACK_TO - 1);
      coin_out_q   <= COIN_NONE;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      residual_q   <= residual_d;
      timer_q      <= timer_d;
      coin_out_q   <= coin_out_d;
      coin_valid_q <= coin_valid_d;
      done_q       <= done_d;
      error_q      <= error_d;
      ready_q      <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign coin_out   = coin_out_q;
  assign coin_valid = coin_valid_q;
  assign done       = done_q;
  assign error      = error_q;
  assign residual   = residual_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Scoreboard bench for the change dispenser: expected coins/done/error queued at stimulus, checked at output.
module tb_vm2002_change_dispenser;

  localparam int unsigned BAL_W  = 16;
  localparam int unsigned INV_W  = 8;
  localparam int unsigned ACK_TO = 512;
  localparam int          INV_MAX = 255;

  logic             clk = 1'b0;
  logic             hrst_n = 1'b0;
  logic             srst = 1'b0;
  logic [BAL_W-1:0] balance_in = '0;
  logic             balance_valid = 1'b0;
  logic             ready;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack = 1'b0;
  logic             refill_valid = 1'b0;
  logic [1:0]       refill_coin = 2'b00;
  logic [INV_W-1:0] refill_count = '0;
  logic             done;
  logic             error;
  logic [BAL_W-1:0] residual;
  logic [INV_W-1:0] q_cnt, d_cnt, n_cnt;

  // kind: 0 coin (val = coin code), 1 done (val = residual), 2 error (val = residual)
  typedef struct {
    int kind;
    int val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   mq = 20, md = 20, mn = 20;
  bit   ack_en = 1'b0;
  bit   force_ack = 1'b0;
  int   cv_cnt = 0;

  vm2002_change_dispenser #(
    .BAL_W (BAL_W), .INV_W (INV_W), .INIT_Q (20), .INIT_D (20), .INIT_N (20), .ACK_TO (ACK_TO)
  ) dut (
    .clk (clk), .hrst_n (hrst_n), .srst (srst),
    .balance_in (balance_in), .balance_valid (balance_valid), .ready (ready),
    .coin_out (coin_out), .coin_valid (coin_valid), .coin_ack (coin_ack),
    .refill_valid (refill_valid), .refill_coin (refill_coin), .refill_count (refill_count),
    .done (done), .error (error), .residual (residual),
    .q_cnt (q_cnt), .d_cnt (d_cnt), .n_cnt (n_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int kind, input int val);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", 32'(kind), 99);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      chk("sb_value", 32'(val), 32'(e.val));
    end
  endtask

  // Output monitor; also plays the coin mechanism, acking in the cycle coin_valid is shown.
  always @(negedge clk) begin
    if (coin_valid) cv_cnt++;
    if (done)  sb_check(1, int'(residual));
    if (error) sb_check(2, int'(residual));
    if (coin_valid && ack_en) sb_check(0, int'(coin_out));
    coin_ack = coin_valid && (ack_en || force_ack);
  end

  // Greedy payout model assuming every coin is acked.
  task automatic expect_bal(input int bal);
    int rem;
    rem = bal;
    if (bal == 0) begin
      push(1, 0);
    end else if (bal % 5 != 0) begin
      push(2, bal);
    end else begin
      forever begin
        if (rem == 0) begin push(1, 0); break; end
        else if (rem >= 25 && mq > 0) begin push(0, 3); mq--; rem -= 25; end
        else if (rem >= 10 && md > 0) begin push(0, 2); md--; rem -= 10; end
        else if (rem >= 5  && mn > 0) begin push(0, 1); mn--; rem -= 5;  end
        else begin push(2, rem); break; end
      end
    end
  endtask

  task automatic send(input int bal);
    int t;
    t = 0;
    @(posedge clk); #2;
    while (!ready && t < 100) begin @(posedge clk); #2; t++; end
    chk("send_ready", 32'(ready), 1);
    balance_in    = BAL_W'(bal);
    balance_valid = 1'b1;
    @(posedge clk); #2;
    balance_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin @(negedge clk); t++; end
    chk("drain_left", 32'(sb.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pay(input int bal);
    expect_bal(bal);
    send(bal);
    drain(200);
  endtask

  task automatic wait_cv();
    int t;
    t = 0;
    while (!coin_valid && t < 50) begin @(posedge clk); #2; t++; end
    chk("coin_valid_seen", 32'(coin_valid), 1);
  endtask

  task automatic refill(input int c, input int cnt);
    @(posedge clk); #2;
    refill_valid = 1'b1;
    refill_coin  = 2'(c);
    refill_count = INV_W'(cnt);
    @(posedge clk); #2;
    refill_valid = 1'b0;
    if (c == 3) mq = (mq + cnt > INV_MAX) ? INV_MAX : mq + cnt;
    if (c == 2) md = (md + cnt > INV_MAX) ? INV_MAX : md + cnt;
    if (c == 1) mn = (mn + cnt > INV_MAX) ? INV_MAX : mn + cnt;
  endtask

  task automatic check_inv(input string tag);
    chk({tag, "_q_cnt"}, 32'(q_cnt), 32'(mq));
    chk({tag, "_d_cnt"}, 32'(d_cnt), 32'(md));
    chk({tag, "_n_cnt"}, 32'(n_cnt), 32'(mn));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_coin_valid"}, 32'(coin_valid), 0);
    chk({tag, "_coin_out"}, 32'(coin_out), 0);
    chk({tag, "_residual"}, 32'(residual), 0);
  endtask

  initial begin
    int cv0;

    // Hard reset state.
    #12;
    check_idle("rst");
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    check_inv("rst");
    #5 hrst_n = 1'b1;

    // 40 cents with same-cycle ack: quarter, dime, nickel, done.
    ack_en = 1'b1;
    pay(40);
    check_inv("pay40");
    chk("pay40_residual", 32'(residual), 0);

    // Zero balance: done two cycles after the strobe, no coin.
    expect_bal(0);
    send(0);
    @(negedge clk);
    chk("zero_done_early", 32'(done), 0);
    chk("zero_no_coin", 32'(coin_valid), 0);
    @(negedge clk);
    chk("zero_done_pulse", 32'(done), 1);
    drain(20);

    // Not a multiple of 5: immediate error, inventory untouched.
    pay(37);
    check_inv("pay37");
    chk("pay37_residual", 32'(residual), 37);

    // Exhaust dimes and nickels, then the greedy dead-end on 30.
    repeat (19) pay(10);
    repeat (19) pay(5);
    check_inv("empty_dn");
    pay(5);
    pay(30);
    check_inv("pay30");
    chk("pay30_q_cnt", 32'(q_cnt), 18);
    chk("pay30_residual", 32'(residual), 5);

    // No ack: timeout after ACK_TO cycles of coin_valid, quarter not deducted.
    ack_en = 1'b0;
    cv0 = cv_cnt;
    push(2, 25);
    send(25);
    drain(ACK_TO + 100);
    chk("ack_to_cycles", 32'(cv_cnt - cv0), ACK_TO);
    check_inv("timeout");

    // Soft reset mid-EMIT together with an ack: coin abandoned, not counted.
    send(25);
    wait_cv();
    repeat (4) begin @(posedge clk); #2; end
    srst = 1'b1;
    force_ack = 1'b1;
    @(posedge clk); #2;
    srst = 1'b0;
    force_ack = 1'b0;
    @(negedge clk);
    check_idle("srst");
    check_inv("srst");
    repeat (3) @(negedge clk);

    // Refills: quarters to 250, ignored code 00, dimes from empty.
    ack_en = 1'b1;
    refill(3, 232);
    refill(0, 5);
    refill(2, 7);
    check_inv("refill");
    chk("refill_q250", 32'(q_cnt), 250);

    // Refill of 10 quarters coincident with a quarter ack saturates at 255.
    expect_bal(25);
    send(25);
    wait_cv();
    refill_valid = 1'b1;
    refill_coin  = 2'd3;
    refill_count = INV_W'(10);
    @(posedge clk); #2;
    refill_valid = 1'b0;
    mq = (mq + 10 > INV_MAX) ? INV_MAX : mq + 10;
    drain(50);
    chk("sat_q_cnt", 32'(q_cnt), 255);
    check_inv("sat");

    // Hard reset mid-payout: immediate idle with initial stock.
    ack_en = 1'b0;
    send(40);
    wait_cv();
    hrst_n = 1'b0;
    #1;
    mq = 20; md = 20; mn = 20;
    check_idle("hrst");
    check_inv("hrst");
    @(negedge clk);
    hrst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal operation after the hard reset.
    ack_en = 1'b1;
    pay(65);
    check_inv("post_hrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
